// File: rtl/prienc_hex_scan_pkg.sv
// Shared constants and helpers for the priority encoder with hex scan display.
// Holds the hex segment table, the blank code and a constant clog2.
package prienc_hex_scan_pkg;

    // Active-high {a,b,c,d,e,f,g,dp} patterns, index 0 is digit 0.
    localparam logic [15:0][7:0] HEX_PAT = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prienc_hex_scan_if.sv
// Request/control inputs and encoder/display outputs of prienc_hex_scan.
interface prienc_hex_scan_if
    import prienc_hex_scan_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_DIGITS = 2
);
    localparam int IDX_W = clog2(WIDTH);

    logic [WIDTH-1:0]      i_req;
    logic                  i_en;
    logic                  i_hold;
    logic [IDX_W-1:0]      o_idx;
    logic                  o_valid;
    logic                  o_chg;
    logic [7:0]            o_seg;
    logic [NUM_DIGITS-1:0] o_an;

    modport master (
        output i_req, i_en, i_hold,
        input  o_idx, o_valid, o_chg, o_seg, o_an
    );

    modport slave (
        input  i_req, i_en, i_hold,
        output o_idx, o_valid, o_chg, o_seg, o_an
    );
endinterface

// File: rtl/prienc_hex_scan_hex7seg.sv
// Combinational nibble to active-low 7-segment decoder with blanking; dp stays off.
module prienc_hex_scan_hex7seg
    import prienc_hex_scan_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [7:0] seg
);
    assign seg = blank ? SEG_BLANK : ~HEX_PAT[nib];
endmodule

// File: rtl/prienc_hex_scan.sv
// Registered priority encoder with change strobe and hold, driving a
// time-multiplexed active-low hex display of the encoded index.
module prienc_hex_scan
    import prienc_hex_scan_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_DIGITS = 2,
    parameter int SCAN_DIV   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    prienc_hex_scan_if.slave bus
);
    localparam int IDX_W = clog2(WIDTH);
    localparam int CNT_W = (SCAN_DIV > 1) ? clog2(SCAN_DIV) : 1;
    localparam int DIG_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam int EXT_W = NUM_DIGITS * 4;

    logic [IDX_W-1:0]      enc_idx;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic                  valid_reg, valid_next;
    logic                  chg_reg, chg_next;
    logic                  primed_reg;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [DIG_W-1:0]      dig_reg, dig_next;
    logic [7:0]            seg_reg, seg_next;
    logic [NUM_DIGITS-1:0] an_reg, an_next;
    logic [EXT_W-1:0]      idx_ext;
    logic [3:0]            nibbles [NUM_DIGITS];
    logic [3:0]            cur_nib;

    // Later (higher) bits overwrite earlier ones, so the highest request wins.
    always_comb begin
        enc_idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (bus.i_req[k]) enc_idx = IDX_W'(k);
        end
    end

    always_comb begin
        idx_next   = idx_reg;
        valid_next = valid_reg;
        if (!bus.i_en) begin
            idx_next   = '0;
            valid_next = 1'b0;
        end else if (!bus.i_hold) begin
            idx_next   = enc_idx;
            valid_next = |bus.i_req;
        end
        // The first edge out of reset only arms the detector.
        chg_next = primed_reg && ({valid_next, idx_next} != {valid_reg, idx_reg});
    end

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        dig_next = dig_reg;
        if (cnt_reg == CNT_W'(SCAN_DIV - 1)) begin
            cnt_next = '0;
            dig_next = (dig_reg == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_reg + 1'b1;
        end
    end

    assign idx_ext = EXT_W'(idx_reg);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign nibbles[gi] = idx_ext[gi*4 +: 4];
        assign an_next[gi] = (dig_reg != DIG_W'(gi));
    end

    always_comb begin
        cur_nib = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dig_reg == DIG_W'(k)) cur_nib = nibbles[k];
        end
    end

    prienc_hex_scan_hex7seg u_hex7seg (
        .nib   (cur_nib),
        .blank (~valid_reg),
        .seg   (seg_next)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_reg    <= '0;
            valid_reg  <= 1'b0;
            chg_reg    <= 1'b0;
            primed_reg <= 1'b0;
            cnt_reg    <= '0;
            dig_reg    <= '0;
            seg_reg    <= SEG_BLANK;
            an_reg     <= ~NUM_DIGITS'(1);
        end else begin
            idx_reg    <= idx_next;
            valid_reg  <= valid_next;
            chg_reg    <= chg_next;
            primed_reg <= 1'b1;
            cnt_reg    <= cnt_next;
            dig_reg    <= dig_next;
            seg_reg    <= seg_next;
            an_reg     <= an_next;
        end
    end

    assign bus.o_idx   = idx_reg;
    assign bus.o_valid = valid_reg;
    assign bus.o_chg   = chg_reg;
    assign bus.o_seg   = seg_reg;
    assign bus.o_an    = an_reg;
endmodule

// File: tb/tb_prienc_hex_scan.sv
// Bench for prienc_hex_scan: a default instance and a WIDTH=8/1-digit/SCAN_DIV=1
// instance, each checked every cycle against a behavioural model plus literals.
module tb_prienc_hex_scan;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    prienc_hex_scan_if #(.WIDTH(16), .NUM_DIGITS(2)) bus0 ();
    prienc_hex_scan_if #(.WIDTH(8),  .NUM_DIGITS(1)) bus1 ();

    prienc_hex_scan #(.WIDTH(16), .NUM_DIGITS(2), .SCAN_DIV(4)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0)
    );

    prienc_hex_scan #(.WIDTH(8), .NUM_DIGITS(1), .SCAN_DIV(1)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    logic [7:0] pat [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int highest(input logic [15:0] r);
        for (int k = 15; k >= 0; k--) begin
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [7:0] disp(input bit v, input int idx, input int d);
        int nib;
        nib = (idx >> (4 * d)) & 15;
        return v ? ~pat[nib] : 8'hFF;
    endfunction

    // Model state: n counts edges since reset; display after edge n shows
    // digit floor((n-1)/SCAN_DIV) mod NUM_DIGITS of the state before that edge.
    int         ma_idx, ma_n, ma_h, ma_ni, ma_d;
    bit         ma_valid, ma_chg, ma_primed, ma_nv;
    logic [7:0] ma_seg;
    logic [1:0] ma_an;
    int         mb_idx, mb_n, mb_h, mb_ni;
    bit         mb_valid, mb_chg, mb_primed, mb_nv;
    logic [7:0] mb_seg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma_idx = 0; ma_valid = 0; ma_chg = 0; ma_primed = 0; ma_n = 0;
            ma_seg = 8'hFF; ma_an = 2'b10;
        end else begin
            ma_n++;
            ma_d   = ((ma_n - 1) / 4) % 2;
            ma_an  = 2'b11 ^ (2'b01 << ma_d);
            ma_seg = disp(ma_valid, ma_idx, ma_d);
            ma_h   = highest(bus0.i_req);
            ma_ni  = ma_idx;
            ma_nv  = ma_valid;
            if (!bus0.i_en) begin
                ma_ni = 0; ma_nv = 0;
            end else if (!bus0.i_hold) begin
                ma_ni = (ma_h < 0) ? 0 : ma_h;
                ma_nv = (ma_h >= 0);
            end
            ma_chg    = ma_primed && ((ma_ni != ma_idx) || (ma_nv != ma_valid));
            ma_primed = 1;
            ma_idx    = ma_ni;
            ma_valid  = ma_nv;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mb_idx = 0; mb_valid = 0; mb_chg = 0; mb_primed = 0; mb_n = 0;
            mb_seg = 8'hFF;
        end else begin
            mb_n++;
            mb_seg = disp(mb_valid, mb_idx, 0);
            mb_h   = highest({8'h00, bus1.i_req});
            mb_ni  = mb_idx;
            mb_nv  = mb_valid;
            if (!bus1.i_en) begin
                mb_ni = 0; mb_nv = 0;
            end else if (!bus1.i_hold) begin
                mb_ni = (mb_h < 0) ? 0 : mb_h;
                mb_nv = (mb_h >= 0);
            end
            mb_chg    = mb_primed && ((mb_ni != mb_idx) || (mb_nv != mb_valid));
            mb_primed = 1;
            mb_idx    = mb_ni;
            mb_valid  = mb_nv;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_a_idx",   32'(bus0.o_idx),   32'(ma_idx));
            chk("m_a_valid", 32'(bus0.o_valid), 32'(ma_valid));
            chk("m_a_chg",   32'(bus0.o_chg),   32'(ma_chg));
            chk("m_a_seg",   32'(bus0.o_seg),   32'(ma_seg));
            chk("m_a_an",    32'(bus0.o_an),    32'(ma_an));
            chk("m_b_idx",   32'(bus1.o_idx),   32'(mb_idx));
            chk("m_b_valid", 32'(bus1.o_valid), 32'(mb_valid));
            chk("m_b_chg",   32'(bus1.o_chg),   32'(mb_chg));
            chk("m_b_seg",   32'(bus1.o_seg),   32'(mb_seg));
            chk("m_b_an",    32'(bus1.o_an),    32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic hold, input logic [15:0] ra, input logic [7:0] rb);
        bus0.i_en = en; bus0.i_hold = hold; bus0.i_req = ra;
        bus1.i_en = en; bus1.i_hold = hold; bus1.i_req = rb;
    endtask

    initial begin
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        #1 rst = 1'b1;
        #1;
        chk("rst_a_idx",   32'(bus0.o_idx),   32'd0);
        chk("rst_a_valid", 32'(bus0.o_valid), 32'd0);
        chk("rst_a_chg",   32'(bus0.o_chg),   32'd0);
        chk("rst_a_seg",   32'(bus0.o_seg),   32'hFF);
        chk("rst_a_an",    32'(bus0.o_an),    32'h2);
        chk("rst_b_an",    32'(bus1.o_an),    32'h0);
        repeat (3) step();
        rst = 1'b0;
        step();
        step();
        chk("idle_a_chg", 32'(bus0.o_chg), 32'd0);

        drive(1'b1, 1'b0, 16'h0005, 8'h05);
        step();
        chk("pri5_a_idx",   32'(bus0.o_idx),   32'd2);
        chk("pri5_a_valid", 32'(bus0.o_valid), 32'd1);
        chk("pri5_a_chg",   32'(bus0.o_chg),   32'd1);
        chk("pri5_b_idx",   32'(bus1.o_idx),   32'd2);
        step();
        chk("pri5_a_chg_end", 32'(bus0.o_chg), 32'd0);

        drive(1'b1, 1'b0, 16'h8001, 8'h01);
        step();
        chk("pri8001_a_idx", 32'(bus0.o_idx),   32'd15);
        chk("pri8001_a_chg", 32'(bus0.o_chg),   32'd1);
        chk("pri01_b_idx",   32'(bus1.o_idx),   32'd0);
        chk("pri01_b_valid", 32'(bus1.o_valid), 32'd1);
        chk("pri01_b_chg",   32'(bus1.o_chg),   32'd1);
        step();
        chk("pri8001_a_chg_end", 32'(bus0.o_chg), 32'd0);

        for (int i = 0; i < 12; i++) begin
            step();
            if (bus0.o_an == 2'b10) begin
                chk("scan_d0_seg", 32'(bus0.o_seg), 32'h71);
            end else begin
                chk("scan_d1_an",  32'(bus0.o_an),  32'h1);
                chk("scan_d1_seg", 32'(bus0.o_seg), 32'h03);
            end
        end

        drive(1'b1, 1'b0, 16'h0008, 8'h08);
        step();
        chk("hold_pre_idx", 32'(bus0.o_idx), 32'd3);
        drive(1'b1, 1'b1, 16'h0100, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_idx",   32'(bus0.o_idx),   32'd3);
            chk("hold_valid", 32'(bus0.o_valid), 32'd1);
            chk("hold_chg",   32'(bus0.o_chg),   32'd0);
        end
        drive(1'b0, 1'b1, 16'h0100, 8'h00);
        step();
        chk("dis_idx",   32'(bus0.o_idx),   32'd0);
        chk("dis_valid", 32'(bus0.o_valid), 32'd0);
        chk("dis_chg",   32'(bus0.o_chg),   32'd1);
        step();
        step();
        chk("dis_seg", 32'(bus0.o_seg), 32'hFF);

        drive(1'b1, 1'b0, 16'h0000, 8'h00);
        step();
        chk("noreq_valid", 32'(bus0.o_valid), 32'd0);
        chk("noreq_chg",   32'(bus0.o_chg),   32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("noreq_seg", 32'(bus0.o_seg), 32'hFF);
        end

        drive(1'b1, 1'b0, 16'h0040, 8'h40);
        step();
        chk("rep_idx", 32'(bus0.o_idx), 32'd6);
        chk("rep_chg", 32'(bus0.o_chg), 32'd1);
        step();
        chk("rep_chg2", 32'(bus0.o_chg), 32'd0);
        step();
        chk("rep_chg3", 32'(bus0.o_chg), 32'd0);

        drive(1'b1, 1'b1, 16'h0200, 8'h02);
        step();
        chk("held_ign_idx", 32'(bus0.o_idx), 32'd6);
        drive(1'b1, 1'b0, 16'h0200, 8'h02);
        step();
        chk("unhold_idx", 32'(bus0.o_idx), 32'd9);
        chk("unhold_chg", 32'(bus0.o_chg), 32'd1);

        drive(1'b1, 1'b0, 16'h8000, 8'h80);
        step();
        chk("sweep_b_idx", 32'(bus1.o_idx), 32'd7);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sweep_b_seg", 32'(bus1.o_seg), 32'h1F);
            chk("sweep_b_an",  32'(bus1.o_an),  32'h0);
        end

        #1 rst = 1'b1;
        #1;
        chk("arst_a_idx",   32'(bus0.o_idx),   32'd0);
        chk("arst_a_valid", 32'(bus0.o_valid), 32'd0);
        chk("arst_a_seg",   32'(bus0.o_seg),   32'hFF);
        chk("arst_a_an",    32'(bus0.o_an),    32'h2);
        chk("arst_b_idx",   32'(bus1.o_idx),   32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_a_idx",   32'(bus0.o_idx),   32'd15);
        chk("post_rst_a_valid", 32'(bus0.o_valid), 32'd1);
        chk("post_rst_a_chg",   32'(bus0.o_chg),   32'd0);
        chk("post_rst_b_chg",   32'(bus1.o_chg),   32'd0);
        step();
        chk("post_rst_a_chg2", 32'(bus0.o_chg), 32'd0);
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
